// File: rtl/banked_dual_port_sram.sv
// Banked scratchpad with two requesters (A: EPU, B: DMA), per-bank round-robin arbitration.
// Optional macro BANKED_SRAM_OUT_REG_EN adds a registered output stage per port (read latency 2).
module banked_dual_port_sram #(
  parameter int DATA_W     = 16,
  parameter int BANK_AW    = 15,
  parameter int NUM_BANKS  = 6,
  parameter int BANK_SEL_W = 3,
  parameter int RDATA_W    = 32,
  localparam int ADDR_W    = BANK_SEL_W + BANK_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_req,
  input  logic               a_we,
  input  logic [ADDR_W-1:0]  a_addr,
  input  logic [DATA_W-1:0]  a_wdata,
  output logic               a_gnt,
  output logic               a_rvalid,
  output logic [RDATA_W-1:0] a_rdata,
  input  logic               b_req,
  input  logic               b_we,
  input  logic [ADDR_W-1:0]  b_addr,
  input  logic [DATA_W-1:0]  b_wdata,
  output logic               b_gnt,
  output logic               b_rvalid,
  output logic [DATA_W-1:0]  b_rdata,
  output logic               err,
  input  logic               clr_err,
  output logic [15:0]        conflict_cnt
);

  localparam int SEL_N = 2 ** BANK_SEL_W;
  localparam logic [BANK_SEL_W:0] NB = (BANK_SEL_W + 1)'(NUM_BANKS);

  typedef enum logic {PTR_A = 1'b0, PTR_B = 1'b1} ptr_t;

  function automatic logic [RDATA_W-1:0] sext(input logic signed [DATA_W-1:0] d);
    return RDATA_W'(d);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic [BANK_SEL_W-1:0] w_a_bank, w_b_bank;
  logic [BANK_AW-1:0]    w_a_off, w_b_off;
  logic                  w_a_oor, w_b_oor, w_conflict;
  logic                  w_a_rd, w_b_rd;
  ptr_t                  r_rr_ptr;
  logic [DATA_W-1:0]     w_dout [SEL_N];

  assign w_a_bank = a_addr[ADDR_W-1:BANK_AW];
  assign w_b_bank = b_addr[ADDR_W-1:BANK_AW];
  assign w_a_off  = a_addr[BANK_AW-1:0];
  assign w_b_off  = b_addr[BANK_AW-1:0];
  assign w_a_oor  = {1'b0, w_a_bank} >= NB;
  assign w_b_oor  = {1'b0, w_b_bank} >= NB;

  // Out-of-range requests never touch a bank, so they never contend.
  assign w_conflict = a_req & b_req & ~w_a_oor & ~w_b_oor & (w_a_bank == w_b_bank);
  assign a_gnt  = a_req & (~w_conflict | (r_rr_ptr == PTR_A));
  assign b_gnt  = b_req & (~w_conflict | (r_rr_ptr == PTR_B));
  assign w_a_rd = a_gnt & ~a_we;
  assign w_b_rd = b_gnt & ~b_we;

  for (genvar g = 0; g < SEL_N; g++) begin : g_bank
    if (g < NUM_BANKS) begin : g_real
      localparam logic [BANK_SEL_W-1:0] ID = BANK_SEL_W'(g);
      logic               w_sel_a, w_sel_b, w_cs, w_web;
      logic [BANK_AW-1:0] w_addr;
      logic [DATA_W-1:0]  w_wdata;
      logic [DATA_W-1:0]  r_mem [2**BANK_AW];
      logic [DATA_W-1:0]  r_dout;

      assign w_sel_a = a_gnt & ~w_a_oor & (w_a_bank == ID);
      assign w_sel_b = b_gnt & ~w_b_oor & (w_b_bank == ID);
      assign w_cs    = w_sel_a | w_sel_b;
      assign w_web   = w_sel_a ? ~a_we : (w_sel_b ? ~b_we : 1'b1);
      assign w_addr  = w_sel_a ? w_a_off : w_b_off;
      assign w_wdata = w_sel_a ? a_wdata : b_wdata;

      always_ff @(posedge clk) begin
        if (w_cs) begin
          if (!w_web) r_mem[w_addr] <= w_wdata;
          else        r_dout        <= r_mem[w_addr];
        end
      end
      assign w_dout[g] = r_dout;
    end else begin : g_empty
      // Unpopulated bank selects read back as zero.
      assign w_dout[g] = '0;
    end
  end

  // Stage p1: latched bank select, read valid and held read data
  logic                  r_a_rvalid_p1, r_b_rvalid_p1;
  logic [BANK_SEL_W-1:0] r_a_sel_p1, r_b_sel_p1;
  logic [DATA_W-1:0]     r_a_hold_p1, r_b_hold_p1;
  logic [DATA_W-1:0]     w_a_dout_p1, w_b_dout_p1, w_a_data_p1, w_b_data_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_rvalid_p1 <= 1'b0;
      r_b_rvalid_p1 <= 1'b0;
      r_a_sel_p1    <= '0;
      r_b_sel_p1    <= '0;
      r_a_hold_p1   <= '0;
      r_b_hold_p1   <= '0;
    end else begin
      r_a_rvalid_p1 <= w_a_rd;
      r_b_rvalid_p1 <= w_b_rd;
      if (w_a_rd) r_a_sel_p1 <= w_a_bank;
      if (w_b_rd) r_b_sel_p1 <= w_b_bank;
      if (r_a_rvalid_p1) r_a_hold_p1 <= w_a_dout_p1;
      if (r_b_rvalid_p1) r_b_hold_p1 <= w_b_dout_p1;
    end
  end

  assign w_a_dout_p1 = w_dout[r_a_sel_p1];
  assign w_b_dout_p1 = w_dout[r_b_sel_p1];
  // The bank output may be overwritten by the other port, so hold our own copy.
  assign w_a_data_p1 = r_a_rvalid_p1 ? w_a_dout_p1 : r_a_hold_p1;
  assign w_b_data_p1 = r_b_rvalid_p1 ? w_b_dout_p1 : r_b_hold_p1;

`ifdef BANKED_SRAM_OUT_REG_EN
  // Stage p2: registered outputs
  logic               r_a_rvalid_p2, r_b_rvalid_p2;
  logic [RDATA_W-1:0] r_a_rdata_p2;
  logic [DATA_W-1:0]  r_b_rdata_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_rvalid_p2 <= 1'b0;
      r_b_rvalid_p2 <= 1'b0;
      r_a_rdata_p2  <= '0;
      r_b_rdata_p2  <= '0;
    end else begin
      r_a_rvalid_p2 <= r_a_rvalid_p1;
      r_b_rvalid_p2 <= r_b_rvalid_p1;
      if (r_a_rvalid_p1) r_a_rdata_p2 <= sext(w_a_dout_p1);
      if (r_b_rvalid_p1) r_b_rdata_p2 <= w_b_dout_p1;
    end
  end

  assign a_rvalid = r_a_rvalid_p2;
  assign b_rvalid = r_b_rvalid_p2;
  assign a_rdata  = r_a_rdata_p2;
  assign b_rdata  = r_b_rdata_p2;
`else
  assign a_rvalid = r_a_rvalid_p1;
  assign b_rvalid = r_b_rvalid_p1;
  assign a_rdata  = sext(w_a_data_p1);
  assign b_rdata  = w_b_data_p1;
`endif

  logic r_err;
  logic [15:0] r_conflict_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err          <= 1'b0;
      r_conflict_cnt <= '0;
      r_rr_ptr       <= PTR_A;
    end else begin
      if (clr_err) begin
        r_err          <= 1'b0;
        r_conflict_cnt <= '0;
      end else begin
        if ((a_gnt & w_a_oor) | (b_gnt & w_b_oor)) r_err <= 1'b1;
        if (w_conflict) r_conflict_cnt <= sat_inc(r_conflict_cnt);
      end
      if (w_conflict) r_rr_ptr <= (r_rr_ptr == PTR_A) ? PTR_B : PTR_A;
    end
  end

  assign err          = r_err;
  assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_banked_dual_port_sram.sv
// Scoreboard bench for banked_dual_port_sram: directed scenarios then randomized traffic
// against an address-level memory model; read responses are checked by an independent monitor.
module tb_banked_dual_port_sram;

`ifdef BANKED_SRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0, clr_err = 0;
  logic [17:0] a_addr = '0, b_addr = '0;
  logic [15:0] a_wdata = '0, b_wdata = '0;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid, err;
  logic [31:0] a_rdata;
  logic [15:0] b_rdata, conflict_cnt;

  banked_dual_port_sram dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .err(err), .clr_err(clr_err), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct { int cyc; logic [31:0] d; } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  logic [15:0] mem_m [int];
  logic        err_m = 0;
  logic [15:0] cnt_m = 0;
  bit          ptr_m = 0;  // 0: A has priority on the next conflict
  logic [31:0] last_a = 0, last_b = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] sext16(input logic [15:0] d);
    return {{16{d[15]}}, d};
  endfunction

  // One bus cycle: drive requests, check grants and status against the model, update the model.
  task automatic step(input logic ar, input logic aw, input logic [17:0] aa, input logic [15:0] ad,
                      input logic br, input logic bw, input logic [17:0] ba, input logic [15:0] bd,
                      input logic clr, output logic ag, output logic bg);
    int  abank, bbank;
    bit  aoor, boor, conf, ea, eb;
    @(posedge clk); #1;
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    clr_err = clr;
    @(negedge clk);
    abank = int'(aa) / 32768;
    bbank = int'(ba) / 32768;
    aoor  = abank >= 6;
    boor  = bbank >= 6;
    conf  = ar && br && !aoor && !boor && (abank == bbank);
    ea    = ar && (!conf || !ptr_m);
    eb    = br && (!conf || ptr_m);
    check("a_gnt", a_gnt, ea);
    check("b_gnt", b_gnt, eb);
    check("err", err, err_m);
    check("conflict_cnt", conflict_cnt, cnt_m);
    ag = a_gnt;
    bg = b_gnt;
    if (ea) begin
      if (aw) begin
        if (!aoor) mem_m[int'(aa)] = ad;
      end else qa.push_back('{cyc + LAT, aoor ? 32'd0 : sext16(mem_m[int'(aa)])});
    end
    if (eb) begin
      if (bw) begin
        if (!boor) mem_m[int'(ba)] = bd;
      end else qb.push_back('{cyc + LAT, boor ? 32'd0 : {16'd0, mem_m[int'(ba)]}});
    end
    if (clr) begin
      err_m = 0;
      cnt_m = 0;
    end else begin
      if ((ea && aoor) || (eb && boor)) err_m = 1;
      if (conf && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
    end
    if (conf) ptr_m = !ptr_m;
  endtask

  task automatic idle(input int n);
    logic g1, g2;
    repeat (n) step(0, 0, 18'd0, 16'd0, 0, 0, 18'd0, 16'd0, 0, g1, g2);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1; a_req = 0; b_req = 0; clr_err = 0;
    qa.delete(); qb.delete();
    err_m = 0; cnt_m = 0; ptr_m = 0;
    repeat (n) begin
      @(negedge clk);
      check("rst_err", err, 1'b0);
      check("rst_cnt", conflict_cnt, 16'd0);
    end
    @(posedge clk); #1;
    rst = 0;
  endtask

  // Monitor: pops expected read responses whenever the DUT presents rvalid.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_a_rvalid", a_rvalid, 1'b0);
      check("rst_b_rvalid", b_rvalid, 1'b0);
      check("rst_a_rdata", a_rdata, 32'd0);
      check("rst_b_rdata", b_rdata, 16'd0);
      last_a = 0;
      last_b = 0;
    end else begin
      if (qa.size() > 0 && qa[0].cyc < cyc) begin
        fail_now("a_rvalid_missing");
        void'(qa.pop_front());
      end
      if (a_rvalid) begin
        if (qa.size() == 0 || qa[0].cyc != cyc) fail_now("a_rvalid_unexpected");
        else begin
          check("a_rdata", a_rdata, qa[0].d);
          last_a = qa[0].d;
          void'(qa.pop_front());
        end
      end else check("a_rdata_hold", a_rdata, last_a);
      if (qb.size() > 0 && qb[0].cyc < cyc) begin
        fail_now("b_rvalid_missing");
        void'(qb.pop_front());
      end
      if (b_rvalid) begin
        if (qb.size() == 0 || qb[0].cyc != cyc) fail_now("b_rvalid_unexpected");
        else begin
          check("b_rdata", {16'd0, b_rdata}, qb[0].d);
          last_b = qb[0].d;
          void'(qb.pop_front());
        end
      end else check("b_rdata_hold", {16'd0, b_rdata}, last_b);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ag, bg;
    logic pa_v, pa_w, pb_v, pb_w;
    logic [17:0] pa_a, pb_a;
    logic [15:0] pa_d, pb_d;

    do_reset(2);

    // Populate offsets 0..7 of every bank so every read in the run has a known value.
    for (int bk = 0; bk < 6; bk++)
      for (int off = 0; off < 8; off++)
        step(0, 0, 18'd0, 16'd0, 1, 1, 18'(bk * 32768 + off), 16'($urandom), 0, ag, bg);

    // Sign-extended read-back after a write.
    step(1, 1, 18'h00005, 16'h8001, 0, 0, 18'd0, 16'd0, 0, ag, bg);
    check("t1_wr_gnt", ag, 1'b1);
    step(1, 0, 18'h00005, 16'd0, 0, 0, 18'd0, 16'd0, 0, ag, bg);
    check("t1_rd_gnt", ag, 1'b1);
    if (LAT > 1) begin
      idle(LAT - 1);
      check("t1_no_early_rvalid", a_rvalid, 1'b0);
    end
    idle(1);
    check("t1_rvalid", a_rvalid, 1'b1);
    check("t1_rdata", a_rdata, 32'hFFFF8001);

    // Different banks in parallel.
    step(1, 0, 18'h08000, 16'd0, 1, 1, 18'h10000, 16'h1234, 0, ag, bg);
    check("t2_gnt", {ag, bg}, 2'b11);
    idle(LAT + 1);
    check("t2_cnt", conflict_cnt, 16'd0);

    // Same-bank contention: grants alternate A, B, A, B.
    step(1, 0, 18'h18000, 16'd0, 1, 0, 18'h18001, 16'd0, 0, ag, bg);
    check("t3_gnt1", {ag, bg}, 2'b10);
    step(1, 0, 18'h18002, 16'd0, 1, 0, 18'h18001, 16'd0, 0, ag, bg);
    check("t3_gnt2", {ag, bg}, 2'b01);
    step(1, 0, 18'h18002, 16'd0, 1, 1, 18'h18003, 16'h5A5A, 0, ag, bg);
    check("t3_gnt3", {ag, bg}, 2'b10);
    step(1, 0, 18'h18003, 16'd0, 1, 1, 18'h18003, 16'h5A5A, 0, ag, bg);
    check("t3_gnt4", {ag, bg}, 2'b01);
    step(1, 0, 18'h18003, 16'd0, 0, 0, 18'd0, 16'd0, 0, ag, bg);
    check("t3_gnt5", {ag, bg}, 2'b10);
    check("t3_cnt", conflict_cnt, 16'd4);
    idle(LAT + 1);

    // Out-of-range read: immediate grant, zero data, sticky err, then clear.
    step(1, 0, 18'h30000, 16'd0, 0, 0, 18'd0, 16'd0, 0, ag, bg);
    check("t4_gnt", ag, 1'b1);
    idle(1);
    check("t4_err", err, 1'b1);
    if (LAT > 1) idle(LAT - 1);
    check("t4_rvalid", a_rvalid, 1'b1);
    check("t4_rdata", a_rdata, 32'd0);
    idle(2);
    check("t4_err_sticky", err, 1'b1);
    step(0, 0, 18'd0, 16'd0, 0, 0, 18'd0, 16'd0, 1, ag, bg);
    idle(1);
    check("t4_err_clr", err, 1'b0);
    check("t4_cnt_clr", conflict_cnt, 16'd0);

    // Streaming reads on B interrupted by reset.
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 18'd0, 16'd0, 1, 0, 18'(i), 16'd0, 0, ag, bg);
      if (i >= LAT) check("t5_stream_rvalid", b_rvalid, 1'b1);
    end
    do_reset(2);
    idle(3);
    check("t5_no_rvalid", b_rvalid, 1'b0);

    // Randomized traffic; a request is held until it is granted.
    pa_v = 0; pb_v = 0;
    pa_w = 0; pb_w = 0; pa_a = '0; pb_a = '0; pa_d = '0; pb_d = '0;
    for (int n = 0; n < 500; n++) begin
      if (!pa_v && $urandom_range(3) != 0) begin
        pa_v = 1; pa_w = $urandom_range(2) == 0; pa_d = 16'($urandom);
        pa_a = 18'($urandom_range(7) * 32768 + $urandom_range(7));
      end
      if (!pb_v && $urandom_range(3) != 0) begin
        pb_v = 1; pb_w = $urandom_range(2) == 0; pb_d = 16'($urandom);
        pb_a = 18'($urandom_range(7) * 32768 + $urandom_range(7));
      end
      step(pa_v, pa_w, pa_a, pa_d, pb_v, pb_w, pb_a, pb_d, $urandom_range(31) == 0, ag, bg);
      if (ag) pa_v = 0;
      if (bg) pb_v = 0;
    end
    idle(LAT + 2);
    check("drain_a", qa.size(), 0);
    check("drain_b", qb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/banked_dual_port_sram.md
Name: banked_dual_port_sram

Overview:
- Parametrised banked scratchpad built from NUM_BANKS single-port SRAM banks. Successor to the fixed six-bank 384kB in/out buffer.
- Serves two requesters through per-bank arbitration:
  - port A: EPU compute engine.
  - port B: DMA.
- Same-bank conflicts are arbitrated round-robin. Accesses to different banks proceed in parallel.
- Adds grant/valid handshakes, out-of-range error reporting and a conflict counter.

Parameters:
- DATA_W, 16, data width per word.
- BANK_AW, 15, word-address width per bank (depth 2^BANK_AW).
- NUM_BANKS, 6, number of banks (1..2^BANK_SEL_W).
- BANK_SEL_W, 3, bank-select field width; ADDR_W = BANK_SEL_W + BANK_AW.
- RDATA_W, 32, port A read-data width. Sign-extended from DATA_W; must be >= DATA_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- a_req  in  1  port A request
- a_we  in  1  port A write enable (1 = write)
- a_addr  in  ADDR_W  port A word address; [ADDR_W-1:BANK_AW] = bank, [BANK_AW-1:0] = offset
- a_wdata  in  DATA_W  port A write data
- a_gnt  out  1  port A request accepted this cycle
- a_rvalid  out  1  port A read data valid
- a_rdata  out  RDATA_W  port A read data, sign-extended
- b_req  in  1  port B request
- b_we  in  1  port B write enable
- b_addr  in  ADDR_W  port B word address
- b_wdata  in  DATA_W  port B write data
- b_gnt  out  1  port B accepted
- b_rvalid  out  1  port B read data valid
- b_rdata  out  DATA_W  port B read data, raw
- err  out  1  sticky out-of-range flag
- clr_err  in  1  synchronous clear of err and conflict_cnt
- conflict_cnt  out  16  saturating count of stalled cycles

Behaviour:
- Reset values: a_gnt, b_gnt, a_rvalid, b_rvalid, err = 0; a_rdata, b_rdata = 0; conflict_cnt = 0; RR pointer = A. Latched bank selects = 0.
- Grant is combinational in the request cycle. A requester holds req, we, addr and wdata stable until its gnt is seen.
- Different banks, or only one port requesting: every request is granted in the same cycle.
- Same bank, both requesting: the RR pointer's port wins; the loser sees gnt = 0.
  - The pointer flips to the loser after each conflict. So the loser wins the next cycle and there is no starvation.
  - conflict_cnt increments by 1 per conflict cycle and saturates at 16'hFFFF.
- Granted write: the addressed bank's CS = 1 and WEB = 0 in the grant cycle. Data is stored at the clock edge. No rvalid follows.
- Granted read: bank CS = 1, WEB = 1. The port's bank select is latched.
  - Next cycle: rvalid = 1, with rdata from the latched bank. Bank OE is gated by the latched select.
  - Latency is exactly 1 cycle.
  - rdata is held until the next read completes.
- Back-to-back granted reads give rvalid every cycle; throughput is 1 access/port/cycle.
- Out-of-range (bank field >= NUM_BANKS):
  - Granted immediately and never conflicts.
  - Write is dropped. A read returns rvalid with rdata = 0.
  - err is set on the next edge. err stays set until clr_err or rst.
- clr_err has priority over a same-cycle set. It also zeroes conflict_cnt.
- Ungranted banks: CS = 0, WEB = 1.
- Read-during-write same address: not possible within one bank, because only one port accesses a bank per cycle.
- Reset mid-operation: pending rvalid is dropped. Memory contents are unspecified.
- Bank instance: the team's 16b x 32768 SRAM macro when DATA_W = 16 and BANK_AW = 15; otherwise an equivalent behavioural array with identical timing.

Optional Feature:
- Macro BANKED_SRAM_OUT_REG_EN.
- Defined:
  - Adds one output register stage per port.
  - Read latency becomes 2 cycles. rvalid and rdata are registered together.
  - Grant behaviour is unchanged, and back-to-back throughput is preserved.
- Undefined: latency 1, as above.

Test Plan:
- Reset, then A writes 16'h8001 @ 0x00005, then A reads 0x00005 -> a_gnt = 1 each cycle; a_rvalid one cycle after the read grant; a_rdata = 32'hFFFF8001.
- A reads 0x08000 (bank1) while B writes 16'h1234 @ 0x10000 (bank2) in the same cycle -> both gnt = 1; conflict_cnt stays 0.
- Both ports request bank3 for 4 consecutive cycles:
  - Grants alternate A, B, A, B.
  - conflict_cnt = 4.
  - Each port's reads return correct data one cycle after its grant.
- A reads 0x30000 (bank6, NUM_BANKS = 6) -> immediate a_gnt; next cycle a_rvalid = 1, a_rdata = 0; err = 1.
  - Then pulse clr_err -> err = 0, conflict_cnt = 0.
- B streams reads of 0x00000..0x00007 back-to-back, with rst asserted mid-stream -> b_rvalid every cycle before reset; 0 immediately on rst; no rvalid after release without new requests.
- With BANKED_SRAM_OUT_REG_EN defined, repeat scenario 1 -> a_rvalid exactly 2 cycles after the grant, same data.
